dcm_prog_ctrl: RTL and testbench

Initiator side of the dcm programming interface. It accepts a frequency-select request from upstream control logic and drives the dcm's update/prog_in handshake. It waits until the dcm reports the new setting on prog_out, then verifies the generated slow clock by counting clk_1 periods per clk_2 period. It sits between the system controller and the dcm, in the same 100 MHz clk domain.

---
 rtl/dcm_pkg.sv | 18 +
 rtl/dcm_prog_ctrl_if.sv | 27 ++
 rtl/edge_sync.sv | 19 +
 rtl/dcm_prog_ctrl.sv | 136 +++++++++++++
 tb/tb_dcm_prog_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dcm_pkg.sv
// Shared types and constants for the dcm programming controller.
package dcm_pkg;

   typedef enum logic [2:0] {IDLE, UPD, ACK, ALIGN, MEAS, FIN} state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ACK_TO  = 2'd1;
   localparam logic [1:0] ERR_RANGE   = 2'd2;
   localparam logic [1:0] ERR_NO_EDGE = 2'd3;

   localparam int EXP_W = 16;

   // Expected clk_1 periods per clk_2 period for a given setting.
   function automatic logic [EXP_W-1:0] exp_count(input logic [2:0] sel);
      return EXP_W'(1) << sel;
   endfunction

endpackage

// File: rtl/dcm_prog_ctrl_if.sv
// Request/dcm-side signal bundle for dcm_prog_ctrl; slave is the controller, master drives it.
interface dcm_prog_ctrl_if #(parameter int CNT_W = 9);

   logic             req;
   logic [2:0]       req_sel;
   logic             clk_1;
   logic             clk_2;
   logic [2:0]       prog_out;
   logic             update;
   logic [2:0]       prog_in;
   logic             busy;
   logic             done;
   logic             err;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] meas;

   modport master (
      output req, req_sel, clk_1, clk_2, prog_out,
      input  update, prog_in, busy, done, err, err_code, meas
   );

   modport slave (
      input  req, req_sel, clk_1, clk_2, prog_out,
      output update, prog_in, busy, done, err, err_code, meas
   );

endinterface

// File: rtl/edge_sync.sv
// Brings an asynchronous clock-like signal into clk: two sync FFs plus a history FF,
// giving a one-cycle strobe on each rising edge.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic [2:0] sh;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sh <= '0;
      else     sh <= {sh[1:0], d};
   end

   assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/dcm_prog_ctrl.sv
// Programs a new dcm setting, waits for the dcm to acknowledge on prog_out, then checks the
// clk_1 count over one clk_2 period against 2^sel; result on done/err/err_code/meas.
module dcm_prog_ctrl
   import dcm_pkg::*;
#(
   parameter int ACK_TIMEOUT = 64,
   parameter int TOL         = 1,
   parameter int CNT_W       = 9
) (
   input  logic           clk,
   input  logic           rst,
   dcm_prog_ctrl_if.slave bus
);

   state_t           state;
   logic             r1, r2;
   logic [2:0]       po_s1, po_s2, tgt;
   logic [CNT_W-1:0] cnt, cnt_inc, meas_nxt;
   logic [CNT_W:0]   exp_v, lim;
   logic signed [CNT_W:0] diff, tol_s;
   logic             guard_hit, range_bad;

   logic             update_q, busy_q, done_q, err_q;
   logic [2:0]       prog_in_q;
   logic [1:0]       code_q;
   logic [CNT_W-1:0] meas_q;

   edge_sync u_sync_1 (.clk(clk), .rst(rst), .d(bus.clk_1), .rise(r1));
   edge_sync u_sync_2 (.clk(clk), .rst(rst), .d(bus.clk_2), .rise(r2));

   assign cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
   assign exp_v     = (CNT_W+1)'(exp_count(tgt));
   assign lim       = (exp_v << 1) + (CNT_W+1)'(2);
   // An r2 in the same cycle always wins over the guard: the period closed in time.
   assign guard_hit = r1 && !r2 && ({1'b0, cnt_inc} >= lim);
   assign meas_nxt  = r1 ? cnt_inc : cnt;
   assign diff      = $signed({1'b0, meas_nxt}) - $signed(exp_v);
   assign tol_s     = (CNT_W+1)'(TOL);
   assign range_bad = (diff > tol_s) || (diff < -tol_s);

   // cnt doubles as the ack-wait timer, the ALIGN guard and the measurement counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         po_s1     <= '0;
         po_s2     <= '0;
         tgt       <= '0;
         cnt       <= '0;
         update_q  <= 1'b0;
         prog_in_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= ERR_NONE;
         meas_q    <= '0;
      end else begin
         po_s1    <= bus.prog_out;
         po_s2    <= po_s1;
         update_q <= 1'b0;
         done_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req) begin
                  prog_in_q <= bus.req_sel;
                  tgt       <= bus.req_sel;
                  err_q     <= 1'b0;
                  code_q    <= ERR_NONE;
                  busy_q    <= 1'b1;
                  update_q  <= 1'b1;
                  state     <= UPD;
               end
            end
            UPD: begin
               cnt   <= '0;
               state <= ACK;
            end
            ACK: begin
               if (po_s2 == tgt) begin
                  cnt   <= '0;
                  state <= ALIGN;
               end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                  code_q <= ERR_ACK_TO;
                  err_q  <= 1'b1;
                  done_q <= 1'b1;
                  state  <= FIN;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            ALIGN: begin
               if (r2) begin
                  cnt   <= '0;
                  state <= MEAS;
               end else if (guard_hit) begin
                  code_q <= ERR_NO_EDGE;
                  err_q  <= 1'b1;
                  done_q <= 1'b1;
                  state  <= FIN;
               end else if (r1) begin
                  cnt <= cnt_inc;
               end
            end
            MEAS: begin
               if (r2) begin
                  meas_q <= meas_nxt;
                  code_q <= range_bad ? ERR_RANGE : ERR_NONE;
                  err_q  <= range_bad;
                  done_q <= 1'b1;
                  state  <= FIN;
               end else if (guard_hit) begin
                  code_q <= ERR_NO_EDGE;
                  err_q  <= 1'b1;
                  done_q <= 1'b1;
                  state  <= FIN;
               end else if (r1) begin
                  cnt <= cnt_inc;
               end
            end
            FIN: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.update   = update_q;
   assign bus.prog_in  = prog_in_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.err_code = code_q;
   assign bus.meas     = meas_q;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Bench for dcm_prog_ctrl: behavioural dcm model (clk_1/clk_2 generator, delayed prog_out ack)
// with expected results computed from the programmed clk_2 divide ratio.
module tb_dcm_prog_ctrl;

   localparam int CNT_W       = 9;
   localparam int ACK_TIMEOUT = 64;
   localparam int TOL         = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   dcm_prog_ctrl_if #(.CNT_W(CNT_W)) bus ();

   dcm_prog_ctrl #(.ACK_TIMEOUT(ACK_TIMEOUT), .TOL(TOL), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   // dcm model knobs: clk_2 rises every gen_n clk_1 rises (0 = clk_2 held low)
   int gen_n   = 1;
   int half_ns = 20;
   int jit_ns  = 0;
   bit stuck   = 1'b0;
   int ack_dly = 4;
   int ack_tmr = 0;
   int last_meas = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // clk_1 / clk_2 generator; edges land on even times, clk posedges on odd times
   initial begin
      int ph;
      ph = 0;
      bus.clk_1 = 1'b0;
      bus.clk_2 = 1'b0;
      #2;
      forever begin
         bus.clk_1 = 1'b1;
         if (gen_n != 0 && ph == 0) bus.clk_2 = 1'b1;
         #(half_ns);
         bus.clk_1 = 1'b0;
         bus.clk_2 = 1'b0;
         #(half_ns + jit_ns * int'($urandom_range(0, 1)));
         ph = (gen_n == 0 || ph + 1 >= gen_n) ? 0 : ph + 1;
      end
   end

   // dcm acknowledges a new setting ack_dly cycles after update unless stuck
   always @(negedge clk) begin
      if (rst) begin
         ack_tmr      = 0;
         bus.prog_out = 3'd0;
      end else if (bus.update) begin
         ack_tmr = ack_dly;
      end else if (ack_tmr > 0) begin
         ack_tmr = ack_tmr - 1;
         if (ack_tmr == 0 && !stuck) bus.prog_out = bus.prog_in;
      end
   end

   task automatic run_trial(input int sel, input int n, input bit stk, input int jit,
                            input bit busy_req, input bit fin_req);
      int cyc, upd_seen, exp_code, exp_m, d;
      bit seen;
      gen_n   = n;
      stuck   = stk;
      jit_ns  = jit;
      ack_dly = $urandom_range(2, 20);
      half_ns = 2 * $urandom_range(10, 17);
      if (stk) begin
         exp_code = 1;
         exp_m    = last_meas;
      end else if (n == 0) begin
         exp_code = 3;
         exp_m    = last_meas;
      end else begin
         d = n - (1 << sel);
         if (d < 0) d = -d;
         exp_code  = (d > TOL) ? 2 : 0;
         exp_m     = n;
         last_meas = n;
      end

      @(negedge clk);
      bus.req     = 1'b1;
      bus.req_sel = 3'(sel);
      @(negedge clk);
      bus.req = 1'b0;
      chk("update_1cyc", 32'(bus.update), 1);
      chk("busy_set", 32'(bus.busy), 1);
      chk("prog_in", 32'(bus.prog_in), sel);

      upd_seen = 1;
      seen     = 1'b0;
      cyc      = 0;
      while (!seen && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (busy_req && cyc == 3) begin
            bus.req     = 1'b1;
            bus.req_sel = 3'(sel ^ 1);
         end else begin
            bus.req = 1'b0;
         end
         if (bus.update) upd_seen++;
         if (bus.done) seen = 1'b1;
      end
      bus.req = 1'b0;
      chk("done_seen", 32'(seen), 1);
      if (stk) chk("timeout_lat", cyc, ACK_TIMEOUT + 1);
      chk("err", 32'(bus.err), 32'(exp_code != 0));
      chk("err_code", 32'(bus.err_code), exp_code);
      chk("meas", 32'(bus.meas), exp_m);
      chk("busy_in_fin", 32'(bus.busy), 1);
      chk("update_once", upd_seen, 1);
      chk("prog_in_held", 32'(bus.prog_in), sel);

      if (fin_req) begin
         bus.req     = 1'b1;
         bus.req_sel = 3'(sel ^ 2);
      end
      @(negedge clk);
      bus.req = 1'b0;
      chk("done_1cyc", 32'(bus.done), 0);
      chk("busy_clr", 32'(bus.busy), 0);
      chk("no_upd_after", 32'(bus.update), 0);
      chk("err_sticky", 32'(bus.err), 32'(exp_code != 0));
      if (fin_req) begin
         @(negedge clk);
         chk("fin_req_ignored", 32'(bus.update), 0);
         chk("fin_req_prog_in", 32'(bus.prog_in), sel);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_update"}, 32'(bus.update), 0);
      chk({tag, "_prog_in"}, 32'(bus.prog_in), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_done"}, 32'(bus.done), 0);
      chk({tag, "_err"}, 32'(bus.err), 0);
      chk({tag, "_err_code"}, 32'(bus.err_code), 0);
      chk({tag, "_meas"}, 32'(bus.meas), 0);
   endtask

   task automatic reset_mid();
      int k;
      gen_n   = 4;
      stuck   = 1'b0;
      jit_ns  = 0;
      half_ns = 30;
      ack_dly = 3;
      @(negedge clk);
      bus.req     = 1'b1;
      bus.req_sel = 3'd2;
      @(negedge clk);
      bus.req = 1'b0;
      k = 0;
      while (bus.prog_out != 3'd2 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("rst_ack_seen", 32'(bus.prog_out), 2);
      repeat (4) @(negedge clk);
      k = 0;
      while (!bus.clk_2 && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("rst_clk2_seen", 32'(bus.clk_2), 1);
      repeat (6) @(negedge clk);
      chk("rst_busy_before", 32'(bus.busy), 1);
      #1;
      rst = 1'b1;
      #1;
      check_all_zero("rst_async");
      @(negedge clk);
      check_all_zero("rst_edge");
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_update", 32'(bus.update), 0);
      end
      rst = 1'b0;
      last_meas = 0;
      repeat (2) @(negedge clk);
      chk("rst_no_update_after", 32'(bus.update), 0);
   endtask

   initial begin
      int sel, mode, e, n;
      bus.req     = 1'b0;
      bus.req_sel = 3'd0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("post_reset");

      run_trial(3, 8, 1'b0, 0, 1'b0, 1'b0);
      run_trial(3, 8, 1'b0, 0, 1'b0, 1'b1);
      run_trial(0, 1, 1'b0, 0, 1'b0, 1'b0);
      run_trial(7, 128, 1'b0, 0, 1'b0, 1'b0);
      run_trial(int'(bus.prog_out ^ 3'd1), 4, 1'b1, 0, 1'b0, 1'b0);
      run_trial(2, 8, 1'b0, 0, 1'b0, 1'b0);
      run_trial(2, 4, 1'b0, 10, 1'b0, 1'b0);
      run_trial(1, 0, 1'b0, 0, 1'b1, 1'b0);

      reset_mid();
      run_trial(5, 32, 1'b0, 0, 1'b0, 1'b0);

      for (int i = 0; i < 12; i++) begin
         sel  = $urandom_range(0, 5);
         mode = $urandom_range(0, 3);
         e    = 1 << sel;
         case (mode)
            0: n = e;
            1: n = (e > 1) ? e - 1 : e;
            2: n = e + 1;
            default: n = 2 * e;
         endcase
         run_trial(sel, n, 1'b0, 10 * int'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
